// File: rtl/seq_det_pkg.sv
// Shared definitions for the 101001 sequence detector and its scan run controller.
package seq_det_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned HIT_W_DEF = 8;

    // Pattern matched by sequence_detector, first bit on the wire is the MSB.
    localparam logic [5:0] DET_PATTERN = 6'b101001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

endpackage

// File: rtl/seq_scan_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat
);

    localparam logic [W-1:0] MAX_VAL = '1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (inc && (value != MAX_VAL)) begin
            value <= value + W'(1);
        end
    end

    assign sat = (value == MAX_VAL);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Run controller for the serial 101001 detector: clear, feed a window of bits,
// count match pulses, then report count, saturation, pass/fail and abort status.
module seq_scan_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned HIT_W        = HIT_W_DEF,
    parameter int unsigned CLR_CYCLES   = 1,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_window_len,
    input  logic [HIT_W-1:0] i_hit_threshold,
    input  logic             i_data,
    input  logic             i_pattern_found,
    output logic             o_det_data,
    output logic             o_det_clear,
    output logic             o_det_enable,
    output logic             o_busy,
    output logic             o_done,
    output logic [HIT_W-1:0] o_hit_count,
    output logic [CNT_W-1:0] o_bit_count,
    output logic             o_overflow,
    output logic             o_pass,
    output logic             o_aborted
);

    scan_state_e      state;
    scan_state_e      state_next;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phase_next;
    logic [CNT_W-1:0] len_q;
    logic [HIT_W-1:0] thr_q;
    logic [HIT_W-1:0] hit_final;
    logic             hit_sat;
    logic             hit_inc;
    logic             run_active;
    logic             accept;

    assign run_active = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN);
    assign accept     = (state == ST_IDLE) && i_start;
    assign hit_inc    = i_pattern_found && ((state == ST_RUN) || (state == ST_DRAIN));
    // Count as it will stand after this edge, so pass sees a hit landing on the last DRAIN cycle.
    assign hit_final  = (hit_inc && !hit_sat) ? (o_hit_count + HIT_W'(1)) : o_hit_count;

    // Enable is registered as "state is RUN", so data gating stays aligned with the window.
    assign o_det_data = o_det_enable && i_data;

    sat_counter #(
        .W(HIT_W)
    ) u_hit_cnt (
        .clk  (i_clk),
        .reset(i_reset),
        .clear(accept),
        .inc  (hit_inc),
        .value(o_hit_count),
        .sat  (hit_sat)
    );

    // Next state; the phase counter is reloaded with (length-1) on every state entry.
    // DRAIN_CYCLES and CLR_CYCLES must be at least 1.
    always_comb begin
        state_next = state;
        phase_next = phase;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_CLEAR;
                    phase_next = CNT_W'(CLR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_next = ST_DONE;
                end else if (phase != '0) begin
                    phase_next = phase - CNT_W'(1);
                end else if (len_q != '0) begin
                    state_next = ST_RUN;
                    phase_next = len_q - CNT_W'(1);
                end else begin
                    state_next = ST_DRAIN;
                    phase_next = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_next = ST_DONE;
                end else if (phase != '0) begin
                    phase_next = phase - CNT_W'(1);
                end else begin
                    state_next = ST_DRAIN;
                    phase_next = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (i_abort || (phase == '0)) begin
                    state_next = ST_DONE;
                end else begin
                    phase_next = phase - CNT_W'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, status outputs (decoded from next state) and run results.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            phase        <= '0;
            len_q        <= '0;
            thr_q        <= '0;
            o_det_clear  <= 1'b0;
            o_det_enable <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_bit_count  <= '0;
            o_overflow   <= 1'b0;
            o_pass       <= 1'b0;
            o_aborted    <= 1'b0;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            o_det_clear  <= (state_next == ST_CLEAR);
            o_det_enable <= (state_next == ST_RUN);
            o_busy       <= (state_next == ST_CLEAR) || (state_next == ST_RUN) ||
                            (state_next == ST_DRAIN);
            o_done       <= (state_next == ST_DONE);
            if (accept) begin
                len_q       <= i_window_len;
                thr_q       <= i_hit_threshold;
                o_bit_count <= '0;
                o_overflow  <= 1'b0;
                o_pass      <= 1'b0;
                o_aborted   <= 1'b0;
            end
            if (state == ST_RUN) begin
                o_bit_count <= o_bit_count + CNT_W'(1);
            end
            if (hit_inc && hit_sat) begin
                o_overflow <= 1'b1;
            end
            if (run_active && i_abort) begin
                o_aborted <= 1'b1;
            end
            if (state_next == ST_DONE) begin
                o_pass <= (hit_final >= thr_q);
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl driving a behavioural 101001 detector model.
module tb_seq_scan_ctrl;
    import seq_det_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned HIT_W = 2;
    localparam int unsigned CLR   = 1;
    localparam int unsigned DRAIN = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] window_len;
    logic [HIT_W-1:0] hit_threshold;
    logic             data;
    logic             pattern_found;
    logic             model_found;
    logic             inject;
    logic             det_data;
    logic             det_clear;
    logic             det_enable;
    logic             busy;
    logic             done;
    logic [HIT_W-1:0] hit_count;
    logic [CNT_W-1:0] bit_count;
    logic             overflow;
    logic             pass;
    logic             aborted;
    logic [5:0]       shreg;

    typedef struct {
        int cyc;
        int hits;
        int bits;
        int ovf;
        int pass;
        int abrt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic en_seen  = 1'b0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(
        .CNT_W       (CNT_W),
        .HIT_W       (HIT_W),
        .CLR_CYCLES  (CLR),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_abort        (abort),
        .i_window_len   (window_len),
        .i_hit_threshold(hit_threshold),
        .i_data         (data),
        .i_pattern_found(pattern_found),
        .o_det_data     (det_data),
        .o_det_clear    (det_clear),
        .o_det_enable   (det_enable),
        .o_busy         (busy),
        .o_done         (done),
        .o_hit_count    (hit_count),
        .o_bit_count    (bit_count),
        .o_overflow     (overflow),
        .o_pass         (pass),
        .o_aborted      (aborted)
    );

    // Detector model: one-cycle match latency, history wiped by clear.
    always @(posedge clk) begin
        if (reset || det_clear) begin
            shreg       <= 6'd0;
            model_found <= 1'b0;
        end else if (det_enable) begin
            shreg       <= {shreg[4:0], det_data};
            model_found <= ({shreg[4:0], det_data} == DET_PATTERN);
        end else begin
            model_found <= 1'b0;
        end
    end
    assign pattern_found = model_found || inject;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int out_vec();
        return 32'({busy, done, det_clear, det_enable, det_data, overflow, pass, aborted,
                    hit_count, bit_count});
    endfunction

    // Monitor: each o_done pulse is matched against the oldest expected run result.
    always @(negedge clk) begin
        exp_t e;
        if (det_enable) en_seen = 1'b1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("hit_count", int'(hit_count), e.hits);
                chk("bit_count", int'(bit_count), e.bits);
                chk("overflow", int'(overflow), e.ovf);
                chk("pass", int'(pass), e.pass);
                chk("aborted", int'(aborted), e.abrt);
            end
        end
    end

    // One run: bits are fed first character first; abort_at>0 aborts in that RUN cycle
    // and re-pulses start in RUN cycle 3.
    task automatic run_scan(input int len, input int thr, input string bits, input int hits,
                            input int ovf, input int pass_e, input int abort_at,
                            input logic inj_clear);
        exp_t e;
        @(negedge clk);
        start         = 1'b1;
        window_len    = CNT_W'(len);
        hit_threshold = HIT_W'(thr);
        e.cyc  = cyc + 1 + CLR + ((abort_at > 0) ? abort_at : (len + DRAIN));
        e.hits = hits;
        e.bits = (abort_at > 0) ? abort_at : len;
        e.ovf  = ovf;
        e.pass = pass_e;
        e.abrt = (abort_at > 0) ? 1 : 0;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        inject = inj_clear;
        repeat (CLR - 1) @(negedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            inject = 1'b0;
            data   = (k < bits.len()) && (bits[k] == 8'h31);
            start  = (abort_at > 0) && (k == 2);
            abort  = (abort_at > 0) && (k == abort_at - 1);
            if ((abort_at > 0) && (k == abort_at - 1)) break;
        end
        @(negedge clk);
        inject = 1'b0;
        data   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        for (int w = 0; (w < 60) && (sb.size() != 0); w++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        data          = 1'b0;
        inject        = 1'b0;
        window_len    = '0;
        hit_threshold = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
        reset = 1'b0;
        @(negedge clk);

        // Two disjoint patterns, the second matching on the last window bit (hit lands in DRAIN).
        run_scan(20, 2, "10100100000000101001", 2, 0, 1, 0, 1'b0);

        // A match pulse in IDLE must not touch the held count.
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        chk("idle_hit_ignored", int'(hit_count), 2);

        // Reset for three cycles in the middle of a run.
        start         = 1'b1;
        window_len    = CNT_W'(20);
        hit_threshold = HIT_W'(1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        data = 1'b1;
        chk("busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_run", out_vec(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_idle", out_vec(), 0);
        data = 1'b0;

        // Overlapping patterns share the middle 1.
        run_scan(12, 2, "10100101001", 2, 0, 1, 0, 1'b0);

        // Zero-length window, zero threshold, spurious pulse during CLEAR.
        en_seen = 1'b0;
        run_scan(0, 0, "", 0, 0, 1, 0, 1'b1);
        chk("len0_enable_never", int'(en_seen), 0);

        // Five patterns into a 2-bit hit counter.
        run_scan(30, 3, "101001101001101001101001101001", 3, 1, 1, 0, 1'b0);

        // Abort in the 7th RUN cycle with a start re-pulse while busy.
        run_scan(20, 1, "", 0, 0, 0, 7, 1'b0);

        // Fresh start in IDLE clears aborted.
        run_scan(0, 0, "", 0, 0, 1, 0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
